// File: rtl/tic_tac_toe_ctrl_if.sv
// Signal bundle between the tic_tac_toe game sequencer (master) and its
// move sources, board and status consumers (slave).
interface tic_tac_toe_ctrl_if;
    // Handshake: a source raises *_req with *_addr and holds both until it
    // sees *_ack high for one cycle; ack is never raised without a request.
    logic       start;
    logic       p_req;
    logic [3:0] p_addr;
    logic       p_ack;
    logic       c_req;
    logic [3:0] c_addr;
    logic       c_ack;
    logic       board_player_move;
    logic [3:0] board_player_addr;
    logic       board_computer_move;
    logic [3:0] board_computer_addr;
    logic       board_clr;
    logic       board_illegal;
    logic       board_win;
    logic       board_tie;
    logic [1:0] board_winner;
    logic [1:0] turn;
    logic       game_over;
    logic [1:0] result;
    logic       illegal_pulse;
    logic       timeout;
    logic [3:0] p_score;
    logic [3:0] c_score;
    logic [3:0] tie_score;
    logic [2:0] dbg_state;

    modport master (
        input  start, p_req, p_addr, c_req, c_addr,
        input  board_illegal, board_win, board_tie, board_winner,
        output p_ack, c_ack,
        output board_player_move, board_player_addr,
        output board_computer_move, board_computer_addr, board_clr,
        output turn, game_over, result, illegal_pulse, timeout,
        output p_score, c_score, tie_score, dbg_state
    );

    modport slave (
        output start, p_req, p_addr, c_req, c_addr,
        output board_illegal, board_win, board_tie, board_winner,
        input  p_ack, c_ack,
        input  board_player_move, board_player_addr,
        input  board_computer_move, board_computer_addr, board_clr,
        input  turn, game_over, result, illegal_pulse, timeout,
        input  p_score, c_score, tie_score, dbg_state
    );
endinterface

// File: rtl/tic_tac_toe_ctrl.sv
// Game sequencer for the tic_tac_toe board: turn arbitration, board clear,
// result decision and saturating scores. Define TTT_TURN_TIMEOUT_EN for turn forfeits.
module tic_tac_toe_ctrl #(
    parameter int SETTLE_CYCLES  = 3,
    parameter int CLR_CYCLES     = 2,
    parameter int FIRST_ALT      = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic                 clk,
    input logic                 rst,
    tic_tac_toe_ctrl_if.master  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_P_WAIT  = 3'd2;
    localparam logic [2:0] S_P_CHECK = 3'd3;
    localparam logic [2:0] S_C_WAIT  = 3'd4;
    localparam logic [2:0] S_C_CHECK = 3'd5;
    localparam logic [2:0] S_OVER    = 3'd6;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] CLR_LAST    = 4'(CLR_CYCLES - 1);

    if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 3..15");
    end
    if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr
        $error("CLR_CYCLES must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sticky_q, sticky_d;
    logic       alt_q, alt_d;
    logic       first_c_q, first_c_d;
    logic       p_ack_q, p_ack_d;
    logic       c_ack_q, c_ack_d;
    logic       board_player_move_q, board_player_move_d;
    logic [3:0] board_player_addr_q, board_player_addr_d;
    logic       board_computer_move_q, board_computer_move_d;
    logic [3:0] board_computer_addr_q, board_computer_addr_d;
    logic       board_clr_q, board_clr_d;
    logic [1:0] turn_q, turn_d;
    logic       game_over_q, game_over_d;
    logic [1:0] result_q, result_d;
    logic       illegal_pulse_q, illegal_pulse_d;
    logic [3:0] p_score_q, p_score_d;
    logic [3:0] c_score_q, c_score_d;
    logic [3:0] tie_score_q, tie_score_d;
    logic       sticky_now;

    assign sticky_now = sticky_q | bus.board_illegal;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

`ifdef TTT_TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;
    logic          to_expired;
    logic          in_wait_d;

    assign to_expired = (to_cnt_q == TO_LAST);
    assign in_wait_d  = (state_d == S_P_WAIT) || (state_d == S_C_WAIT);
    // Restarts on every WAIT entry, including a return after a rejected move.
    assign to_cnt_d   = (in_wait_d && state_d == state_q) ? to_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        sticky_d              = sticky_q;
        alt_d                 = alt_q;
        first_c_d             = first_c_q;
        p_ack_d               = 1'b0;
        c_ack_d               = 1'b0;
        board_player_move_d   = 1'b0;
        board_player_addr_d   = board_player_addr_q;
        board_computer_move_d = 1'b0;
        board_computer_addr_d = board_computer_addr_q;
        illegal_pulse_d       = 1'b0;
        result_d              = result_q;
        p_score_d             = p_score_q;
        c_score_d             = c_score_q;
        tie_score_d           = tie_score_q;
`ifdef TTT_TURN_TIMEOUT_EN
        timeout_d             = 1'b0;
`endif

        if (bus.start) begin
            // New game or abort; alt_q holds the first mover of the game being started.
            state_d   = S_CLEAR;
            cnt_d     = 4'd0;
            result_d  = 2'b00;
            first_c_d = (FIRST_ALT != 0) ? alt_q : 1'b0;
            alt_d     = ~alt_q;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (cnt_q == CLR_LAST) begin
                        state_d = first_c_q ? S_C_WAIT : S_P_WAIT;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_P_WAIT: begin
                    // !p_ack_q keeps a request still held during its ack cycle from being taken twice.
                    if (bus.p_req && !p_ack_q) begin
                        p_ack_d = 1'b1;
                        if (bus.p_addr <= 4'd8) begin
                            board_player_move_d = 1'b1;
                            board_player_addr_d = bus.p_addr;
                            state_d             = S_P_CHECK;
                            cnt_d               = 4'd0;
                            sticky_d            = 1'b0;
                        end else begin
                            illegal_pulse_d = 1'b1;
                        end
                    end
`ifdef TTT_TURN_TIMEOUT_EN
                    else if (to_expired) begin
                        timeout_d = 1'b1;
                        result_d  = 2'b10;
                        c_score_d = sat_inc(c_score_q);
                        state_d   = S_OVER;
                    end
`endif
                end
                S_C_WAIT: begin
                    if (bus.c_req && !c_ack_q) begin
                        c_ack_d = 1'b1;
                        if (bus.c_addr <= 4'd8) begin
                            board_computer_move_d = 1'b1;
                            board_computer_addr_d = bus.c_addr;
                            state_d               = S_C_CHECK;
                            cnt_d                 = 4'd0;
                            sticky_d              = 1'b0;
                        end else begin
                            illegal_pulse_d = 1'b1;
                        end
                    end
`ifdef TTT_TURN_TIMEOUT_EN
                    else if (to_expired) begin
                        timeout_d = 1'b1;
                        result_d  = 2'b01;
                        p_score_d = sat_inc(p_score_q);
                        state_d   = S_OVER;
                    end
`endif
                end
                S_P_CHECK, S_C_CHECK: begin
                    sticky_d = sticky_now;
                    if (cnt_q == SETTLE_LAST) begin
                        // Win is tested before tie so a transient tie on a winning move is ignored.
                        if (sticky_now) begin
                            illegal_pulse_d = 1'b1;
                            state_d = (state_q == S_P_CHECK) ? S_P_WAIT : S_C_WAIT;
                        end else if (bus.board_win) begin
                            result_d = bus.board_winner;
                            if (bus.board_winner == 2'b01) begin
                                p_score_d = sat_inc(p_score_q);
                            end else if (bus.board_winner == 2'b10) begin
                                c_score_d = sat_inc(c_score_q);
                            end
                            state_d = S_OVER;
                        end else if (bus.board_tie) begin
                            result_d    = 2'b11;
                            tie_score_d = sat_inc(tie_score_q);
                            state_d     = S_OVER;
                        end else begin
                            state_d = (state_q == S_P_CHECK) ? S_C_WAIT : S_P_WAIT;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        turn_d = 2'b00;
        if (state_d == S_P_WAIT) begin
            turn_d = 2'b01;
        end else if (state_d == S_C_WAIT) begin
            turn_d = 2'b10;
        end
        board_clr_d = (state_d == S_CLEAR);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= S_IDLE;
            cnt_q                 <= 4'd0;
            sticky_q              <= 1'b0;
            alt_q                 <= 1'b0;
            first_c_q             <= 1'b0;
            p_ack_q               <= 1'b0;
            c_ack_q               <= 1'b0;
            board_player_move_q   <= 1'b0;
            board_player_addr_q   <= 4'd0;
            board_computer_move_q <= 1'b0;
            board_computer_addr_q <= 4'd0;
            board_clr_q           <= 1'b0;
            turn_q                <= 2'b00;
            game_over_q           <= 1'b0;
            result_q              <= 2'b00;
            illegal_pulse_q       <= 1'b0;
            p_score_q             <= 4'd0;
            c_score_q             <= 4'd0;
            tie_score_q           <= 4'd0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            sticky_q              <= sticky_d;
            alt_q                 <= alt_d;
            first_c_q             <= first_c_d;
            p_ack_q               <= p_ack_d;
            c_ack_q               <= c_ack_d;
            board_player_move_q   <= board_player_move_d;
            board_player_addr_q   <= board_player_addr_d;
            board_computer_move_q <= board_computer_move_d;
            board_computer_addr_q <= board_computer_addr_d;
            board_clr_q           <= board_clr_d;
            turn_q                <= turn_d;
            game_over_q           <= game_over_d;
            result_q              <= result_d;
            illegal_pulse_q       <= illegal_pulse_d;
            p_score_q             <= p_score_d;
            c_score_q             <= c_score_d;
            tie_score_q           <= tie_score_d;
        end
    end

    assign bus.p_ack               = p_ack_q;
    assign bus.c_ack               = c_ack_q;
    assign bus.board_player_move   = board_player_move_q;
    assign bus.board_player_addr   = board_player_addr_q;
    assign bus.board_computer_move = board_computer_move_q;
    assign bus.board_computer_addr = board_computer_addr_q;
    assign bus.board_clr           = board_clr_q;
    assign bus.turn                = turn_q;
    assign bus.game_over           = game_over_q;
    assign bus.result              = result_q;
    assign bus.illegal_pulse       = illegal_pulse_q;
    assign bus.p_score             = p_score_q;
    assign bus.c_score             = c_score_q;
    assign bus.tie_score           = tie_score_q;
    assign bus.dbg_state           = state_q;

endmodule

// File: tb/tb_tic_tac_toe_ctrl.sv
// Directed bench for tic_tac_toe_ctrl with a registered board model
// (occupancy masks, line detection, optional one-cycle spurious tie).
module tb_tic_tac_toe_ctrl;
    localparam int SETTLE = 3;
    localparam int CLR    = 2;
    localparam int TO     = 20;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    tic_tac_toe_ctrl_if bus ();

    tic_tac_toe_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .CLR_CYCLES    (CLR),
        .FIRST_ALT     (0),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Board model: flags register one cycle after a strobe.
    logic [8:0] pmask, cmask, np, nc;
    logic       ill_n, spur_drop;
    bit         spur_en = 1'b0;

    function automatic bit has_line(input logic [8:0] m);
        return ((m & 9'h007) == 9'h007) || ((m & 9'h038) == 9'h038) ||
               ((m & 9'h1C0) == 9'h1C0) || ((m & 9'h049) == 9'h049) ||
               ((m & 9'h092) == 9'h092) || ((m & 9'h124) == 9'h124) ||
               ((m & 9'h111) == 9'h111) || ((m & 9'h054) == 9'h054);
    endfunction

    always_comb begin
        np    = pmask;
        nc    = cmask;
        ill_n = 1'b0;
        if (bus.board_player_move) begin
            if (bus.board_player_addr > 4'd8) ill_n = 1'b1;
            else if (pmask[bus.board_player_addr] || cmask[bus.board_player_addr]) ill_n = 1'b1;
            else np[bus.board_player_addr] = 1'b1;
        end
        if (bus.board_computer_move) begin
            if (bus.board_computer_addr > 4'd8) ill_n = 1'b1;
            else if (pmask[bus.board_computer_addr] || cmask[bus.board_computer_addr]) ill_n = 1'b1;
            else nc[bus.board_computer_addr] = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst || bus.board_clr) begin
            pmask <= '0; cmask <= '0; spur_drop <= 1'b0;
            bus.board_illegal <= 1'b0; bus.board_win <= 1'b0;
            bus.board_tie <= 1'b0; bus.board_winner <= 2'b00;
        end else begin
            pmask <= np;
            cmask <= nc;
            bus.board_illegal <= ill_n;
            if (spur_drop) begin
                bus.board_tie <= 1'b0;
                spur_drop <= 1'b0;
            end
            if ((bus.board_player_move || bus.board_computer_move) && !ill_n && !bus.board_win) begin
                if (has_line(np)) begin
                    bus.board_win <= 1'b1; bus.board_winner <= 2'b01;
                end else if (has_line(nc)) begin
                    bus.board_win <= 1'b1; bus.board_winner <= 2'b10;
                end
                if ((np | nc) == 9'h1FF) begin
                    if (!has_line(np) && !has_line(nc)) begin
                        bus.board_tie <= 1'b1;
                    end else if (spur_en) begin
                        bus.board_tie <= 1'b1;
                        spur_drop <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_game(output int clr_cycles);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        clr_cycles = bus.board_clr ? 1 : 0;
        bus.start = 1'b0;
        for (int i = 0; i < 50 && bus.turn == 2'b00; i++) begin
            @(negedge clk);
            if (bus.board_clr) clr_cycles++;
        end
    endtask

    task automatic move(input bit is_c, input logic [3:0] a, output bit acked,
                        output logic strobe, output logic [3:0] saddr, output logic ill);
        @(negedge clk);
        if (is_c) begin bus.c_req = 1'b1; bus.c_addr = a; end
        else begin bus.p_req = 1'b1; bus.p_addr = a; end
        acked = 1'b0; strobe = 1'b0; saddr = 4'd0; ill = 1'b0;
        for (int i = 0; i < 100 && !acked; i++) begin
            @(negedge clk);
            if (is_c ? bus.c_ack : bus.p_ack) begin
                acked  = 1'b1;
                strobe = is_c ? bus.board_computer_move : bus.board_player_move;
                saddr  = is_c ? bus.board_computer_addr : bus.board_player_addr;
                ill    = bus.illegal_pulse;
            end
        end
        if (is_c) bus.c_req = 1'b0;
        else bus.p_req = 1'b0;
    endtask

    // Alternating moves starting with the player; good counts cleanly strobed moves.
    task automatic play(input logic [35:0] seq, input int n, output int good);
        bit ak; logic st, il; logic [3:0] sa;
        good = 0;
        for (int k = 0; k < n; k++) begin
            move(k[0], seq[4*k +: 4], ak, st, sa, il);
            if (ak && st && sa == seq[4*k +: 4] && !il) good++;
        end
    endtask

    task automatic wait_over(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.game_over) ok = 1'b1;
        end
    endtask

    task automatic wait_turn(output logic [1:0] t, output int ill_cnt);
        ill_cnt = 0;
        t = 2'b00;
        for (int i = 0; i < 50 && t == 2'b00; i++) begin
            @(negedge clk);
            if (bus.illegal_pulse) ill_cnt++;
            t = bus.turn;
        end
    endtask

    localparam logic [35:0] WIN_SEQ  = {16'h0, 4'd2, 4'd4, 4'd1, 4'd3, 4'd0};
    localparam logic [35:0] DRAW_SEQ = {4'd8, 4'd6, 4'd7, 4'd5, 4'd3, 4'd4, 4'd2, 4'd1, 4'd0};
    localparam logic [35:0] SPUR_SEQ = {4'd8, 4'd6, 4'd7, 4'd4, 4'd5, 4'd3, 4'd2, 4'd1, 4'd0};

    // ---------------- tests ----------------
    task automatic test_reset;
        n_total++; if (bus.turn !== 2'b00) $display("FAIL reset_turn: got %b exp 00", bus.turn); else n_pass++;
        n_total++; if (bus.result !== 2'b00) $display("FAIL reset_result: got %b exp 00", bus.result); else n_pass++;
        n_total++; if ({bus.p_score, bus.c_score, bus.tie_score} !== 12'h000)
            $display("FAIL reset_scores: got %h exp 000", {bus.p_score, bus.c_score, bus.tie_score}); else n_pass++;
        n_total++; if ({bus.p_ack, bus.c_ack, bus.board_player_move, bus.board_computer_move,
                        bus.board_clr, bus.game_over, bus.illegal_pulse, bus.timeout} !== 8'h00)
            $display("FAIL reset_flags: got %b exp 00000000", {bus.p_ack, bus.c_ack, bus.board_player_move,
                     bus.board_computer_move, bus.board_clr, bus.game_over, bus.illegal_pulse, bus.timeout});
        else n_pass++;
    endtask

    task automatic test_player_win;
        int n, good, acks; bit ok;
        start_game(n);
        n_total++; if (n !== CLR) $display("FAIL start_clr_cycles: got %0d exp %0d", n, CLR); else n_pass++;
        n_total++; if (bus.turn !== 2'b01) $display("FAIL first_turn: got %b exp 01", bus.turn); else n_pass++;
        play(WIN_SEQ, 5, good);
        n_total++; if (good !== 5) $display("FAIL win_moves: got %0d exp 5", good); else n_pass++;
        wait_over(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL win_game_over: got %0d exp 1", ok); else n_pass++;
        n_total++; if (bus.result !== 2'b01) $display("FAIL win_result: got %b exp 01", bus.result); else n_pass++;
        n_total++; if (bus.p_score !== 4'd1 || bus.c_score !== 4'd0)
            $display("FAIL win_scores: got p=%0d c=%0d exp p=1 c=0", bus.p_score, bus.c_score); else n_pass++;
        bus.p_req = 1'b1; bus.p_addr = 4'd5; bus.c_req = 1'b1; bus.c_addr = 4'd6;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.p_ack || bus.c_ack) acks++;
        end
        bus.p_req = 1'b0; bus.c_req = 1'b0;
        n_total++; if (acks !== 0) $display("FAIL over_no_ack: got %0d exp 0", acks); else n_pass++;
        n_total++; if (bus.game_over !== 1'b1 || bus.result !== 2'b01)
            $display("FAIL over_hold: got go=%b res=%b exp go=1 res=01", bus.game_over, bus.result); else n_pass++;
    endtask

    task automatic test_illegal_move;
        int n, ic; bit ak; logic st, il; logic [3:0] sa; logic [1:0] t;
        start_game(n);
        move(1'b0, 4'd4, ak, st, sa, il);
        wait_turn(t, ic);
        n_total++; if (t !== 2'b10) $display("FAIL p4_turn: got %b exp 10", t); else n_pass++;
        move(1'b1, 4'd4, ak, st, sa, il);
        n_total++; if (!(ak && st && sa == 4'd4)) $display("FAIL c4_strobe: got ack=%0d st=%b addr=%0d exp 1/1/4", ak, st, sa); else n_pass++;
        wait_turn(t, ic);
        n_total++; if (ic !== 1) $display("FAIL c4_illegal_pulses: got %0d exp 1", ic); else n_pass++;
        n_total++; if (t !== 2'b10) $display("FAIL c4_turn_stays: got %b exp 10", t); else n_pass++;
        move(1'b1, 4'd5, ak, st, sa, il);
        wait_turn(t, ic);
        n_total++; if (!(ak && st && sa == 4'd5) || t !== 2'b01 || ic !== 0)
            $display("FAIL c5_accept: got ack=%0d addr=%0d turn=%b ill=%0d exp 1/5/01/0", ak, sa, t, ic); else n_pass++;
    endtask

    task automatic test_bad_addr;
        bit ak; logic st, il; logic [3:0] sa;
        move(1'b0, 4'd12, ak, st, sa, il);
        n_total++; if (!(ak && il)) $display("FAIL bad_addr_ack: got ack=%0d ill=%b exp 1/1", ak, il); else n_pass++;
        n_total++; if (st !== 1'b0) $display("FAIL bad_addr_strobe: got %b exp 0", st); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.turn !== 2'b01 || bus.illegal_pulse !== 1'b0)
            $display("FAIL bad_addr_after: got turn=%b ill=%b exp 01/0", bus.turn, bus.illegal_pulse); else n_pass++;
    endtask

    task automatic test_hold_creq;
        int early; bit ak, cak; logic st, il; logic [3:0] sa, ca;
        bus.c_req = 1'b1; bus.c_addr = 4'd6;
        early = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.c_ack) early++;
        end
        n_total++; if (early !== 0) $display("FAIL creq_in_pwait: got %0d acks exp 0", early); else n_pass++;
        move(1'b0, 4'd0, ak, st, sa, il);
        cak = 1'b0; ca = 4'd0;
        for (int i = 0; i < 30 && !cak; i++) begin
            @(negedge clk);
            if (bus.c_ack) begin cak = 1'b1; ca = bus.board_computer_addr; end
        end
        bus.c_req = 1'b0;
        n_total++; if (!(cak && ca == 4'd6)) $display("FAIL creq_pending_ack: got ack=%0d addr=%0d exp 1/6", cak, ca); else n_pass++;
    endtask

    task automatic test_abort;
        int n;
        start_game(n);
        n_total++; if (n !== CLR) $display("FAIL abort_clr_cycles: got %0d exp %0d", n, CLR); else n_pass++;
        n_total++; if (bus.p_score !== 4'd1 || bus.result !== 2'b00 || bus.turn !== 2'b01)
            $display("FAIL abort_state: got p=%0d res=%b turn=%b exp 1/00/01", bus.p_score, bus.result, bus.turn); else n_pass++;
    endtask

    task automatic test_draw;
        int good; bit ok;
        play(DRAW_SEQ, 9, good);
        wait_over(ok);
        n_total++; if (good !== 9 || !ok) $display("FAIL draw_moves: got %0d over=%0d exp 9/1", good, ok); else n_pass++;
        n_total++; if (bus.result !== 2'b11) $display("FAIL draw_result: got %b exp 11", bus.result); else n_pass++;
        n_total++; if (bus.tie_score !== 4'd1 || bus.p_score !== 4'd1)
            $display("FAIL draw_scores: got tie=%0d p=%0d exp 1/1", bus.tie_score, bus.p_score); else n_pass++;
    endtask

    task automatic test_spurious_tie;
        int n, good; bit ok;
        spur_en = 1'b1;
        start_game(n);
        play(SPUR_SEQ, 9, good);
        wait_over(ok);
        spur_en = 1'b0;
        n_total++; if (bus.result !== 2'b01 || !ok) $display("FAIL spur_result: got %b over=%0d exp 01/1", bus.result, ok); else n_pass++;
        n_total++; if (bus.tie_score !== 4'd1 || bus.p_score !== 4'd2)
            $display("FAIL spur_scores: got tie=%0d p=%0d exp 1/2", bus.tie_score, bus.p_score); else n_pass++;
    endtask

    task automatic test_saturation;
        int n, good, sum; bit ok;
        sum = 0;
        for (int g = 0; g < 13; g++) begin
            start_game(n);
            play(WIN_SEQ, 5, good);
            wait_over(ok);
            sum += good;
        end
        n_total++; if (bus.p_score !== 4'd15 || sum !== 65) $display("FAIL sat_reach: got p=%0d moves=%0d exp 15/65", bus.p_score, sum); else n_pass++;
        start_game(n);
        play(WIN_SEQ, 5, good);
        wait_over(ok);
        n_total++; if (bus.p_score !== 4'd15 || bus.result !== 2'b01) $display("FAIL sat_hold: got p=%0d res=%b exp 15/01", bus.p_score, bus.result); else n_pass++;
        n_total++; if (bus.c_score !== 4'd0 || bus.tie_score !== 4'd1)
            $display("FAIL sat_others: got c=%0d tie=%0d exp 0/1", bus.c_score, bus.tie_score); else n_pass++;
    endtask

    task automatic test_reset_midgame;
        int n; bit ak; logic st, il; logic [3:0] sa;
        start_game(n);
        move(1'b0, 4'd0, ak, st, sa, il);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if ({bus.p_score, bus.tie_score, bus.turn, bus.result, bus.game_over, bus.board_clr} !== 14'h0)
            $display("FAIL midgame_reset: got p=%0d tie=%0d turn=%b res=%b go=%b clr=%b exp all 0",
                     bus.p_score, bus.tie_score, bus.turn, bus.result, bus.game_over, bus.board_clr);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef TTT_TURN_TIMEOUT_EN
    task automatic test_timeout;
        int n; bit got;
        start_game(n);
        n = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (bus.turn == 2'b01) n++;
            @(negedge clk);
            if (bus.timeout) got = 1'b1;
        end
        n_total++; if (!got || n !== TO) $display("FAIL timeout_cycle: got seen=%0d wait=%0d exp 1/%0d", got, n, TO); else n_pass++;
        n_total++; if (bus.result !== 2'b10 || bus.c_score !== 4'd1)
            $display("FAIL timeout_result: got res=%b c=%0d exp 10/1", bus.result, bus.c_score); else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.p_req = 1'b0; bus.p_addr = 4'd0;
        bus.c_req = 1'b0; bus.c_addr = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_player_win();
        test_illegal_move();
        test_bad_addr();
        test_hold_creq();
        test_abort();
        test_draw();
        test_spurious_tie();
        test_saturation();
        test_reset_midgame();
`ifdef TTT_TURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tic_tac_toe_ctrl.md
Name: tic_tac_toe_ctrl

Overview:
Game sequencer for the tic_tac_toe board. Arbitrates turns between the player and computer move sources and issues single-cycle move strobes with addresses to the board. Waits for the board's registered illegal/win/tie flags to settle, then decides the next turn or the game result. Drives the board clear at game start and keeps saturating score counters.

Parameters:
SETTLE_CYCLES, 3, cycles in CHECK after a strobe before sampling board flags (legal range 3..15)
CLR_CYCLES, 2, cycles board_clr is held high at game start (legal range 1..15)
FIRST_ALT, 0, 1 = first mover alternates each game; 0 = player always first
TIMEOUT_CYCLES, 1000, turn timeout length (used only with TTT_TURN_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  level; starts a new game, or aborts and restarts the current one
p_req  in  1  player move request, held until p_ack
p_addr  in  4  player square, 0..8
p_ack  out  1  one-cycle acceptance of a player request
c_req  in  1  computer move request, held until c_ack
c_addr  in  4  computer square, 0..8
c_ack  out  1  one-cycle acceptance of a computer request
board_player_move  out  1  one-cycle strobe to the board
board_player_addr  out  4  square for the player strobe
board_computer_move  out  1  one-cycle strobe to the board
board_computer_addr  out  4  square for the computer strobe
board_clr  out  1  active-high board clear (top level inverts it into the board's rstn)
board_illegal  in  1  board illegal_move flag
board_win  in  1  board win flag
board_tie  in  1  board tie flag
board_winner  in  2  board winner (01 = player, 10 = computer)
turn  out  2  01 = player to move, 10 = computer to move, 00 = no turn
game_over  out  1  high in OVER
result  out  2  01 = player won, 10 = computer won, 11 = tie, 00 = none or aborted
illegal_pulse  out  1  one cycle per rejected move
timeout  out  1  one-cycle forfeit pulse
p_score  out  4  player wins, saturates at 15
c_score  out  4  computer wins, saturates at 15
tie_score  out  4  ties, saturates at 15

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; all strobes, acks, pulses, board_clr, game_over = 0; turn = 00; result = 00; scores = 0; first-mover toggle = player. Reset mid-game returns to these values immediately.
- States: IDLE, CLEAR, P_WAIT, P_CHECK, C_WAIT, C_CHECK, OVER.
- IDLE / OVER: when start = 1, go to CLEAR and set result = 00. OVER otherwise holds game_over = 1 and keeps result.
- start = 1 in any other state: abort to CLEAR. Scores are unchanged.
- CLEAR: board_clr = 1 for CLR_CYCLES cycles, then go to the first mover's WAIT state. With FIRST_ALT = 1, the first mover toggles on every entry to CLEAR.
- P_WAIT: turn = 01.
  - p_req = 1 and p_addr <= 8: in the next cycle, p_ack = 1, board_player_move = 1 and board_player_addr = p_addr for exactly one cycle; go to P_CHECK.
  - p_req = 1 and p_addr >= 9: p_ack and illegal_pulse for one cycle, no strobe, stay in P_WAIT.
  - c_req is ignored (no c_ack).
- C_WAIT / C_CHECK: mirror of P_WAIT / P_CHECK with the computer signals.
- X_CHECK: turn = 00; counts SETTLE_CYCLES cycles. board_illegal is OR-captured into a sticky flag over the window. At the last cycle, in priority order:
  - sticky illegal: illegal_pulse for one cycle; return to the same WAIT.
  - board_win: result = board_winner; increment that side's score; go to OVER.
  - board_tie: result = 11; increment tie_score; go to OVER.
  - otherwise: go to the other side's WAIT.
- Win has priority over tie. The board can raise a spurious tie for one cycle when the last move also wins; the settle window of 3 or more cycles absorbs it.
- Requests arriving in CHECK, CLEAR, IDLE or OVER are not acked and stay pending.
- Counters saturate at 15; they never wrap.

Optional Feature:
TTT_TURN_TIMEOUT_EN
- Defined: a counter runs in X_WAIT and resets on every WAIT entry. On reaching TIMEOUT_CYCLES the waiting side forfeits: timeout pulses for one cycle, result = the opponent (01 or 10), the opponent's score increments, go to OVER.
- Not defined: WAIT states wait indefinitely; timeout is tied to 0; no counter logic is built.

Test Plan:
- Start, then player 0, computer 3, player 1, computer 4, player 2 (model board, SETTLE = 3) -> result = 01, p_score = 1, game_over = 1, no further acks.
- Player moves to 4, then computer requests 4 (board_illegal = 1 one cycle after strobe) -> illegal_pulse one cycle, turn stays 10; computer 5 then accepted.
- Player request with p_addr = 12 -> p_ack + illegal_pulse, no board_player_move, turn stays 01.
- Full 9-move draw -> result = 11, tie_score = 1. Last move both wins and shows a one-cycle spurious tie -> result = winner, tie_score unchanged.
- c_req held during P_WAIT -> no c_ack until turn = 10. start mid-game -> board_clr high 2 cycles, scores unchanged, result = 00.
- With TTT_TURN_TIMEOUT_EN and TIMEOUT_CYCLES = 20, no player request -> timeout pulse at cycle 20 of P_WAIT, result = 10, c_score +1. Scores at 15 plus another win -> stay 15.
